// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scans the enabled channels of an 8-channel SPI ADC.
// Every frame sends the address of the next channel to convert and returns
// the conversion of the address sent in the previous frame, so each scan
// starts with one extra frame whose result is thrown away.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | cs_n high, sclk high, waiting for an accepted start
//   SETUP | cs_n low, sclk high, CLK_DIV cycles before the first edge
//   SHIFT | 16 sclk periods: din changes on fall, dout sampled on rise
//   HOLD  | cs_n high, sclk high, CLK_DIV cycles; sample published here
//
// SMP_W must lie in 2..16: the result is the tail of the 16 frame bits.
module adc_scan_ctrl #(
  parameter int CLK_DIV = 10,
  parameter int SMP_W   = 12
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             start,
  input  logic             continuous,
  input  logic [7:0]       chan_mask,
  output logic             adc_0_sclk,
  output logic             adc_0_cs_n,
  output logic             adc_0_din,
  input  logic             adc_0_dout,
  output logic [SMP_W-1:0] smp_data,
  output logic [2:0]       smp_chan,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic             busy,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [7:0] TMR_LOAD = 8'(CLK_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       tmr_q, tmr_d;
  logic [3:0]       bit_q, bit_d;
  logic             phase_q, phase_d;
  logic [SMP_W-1:0] shift_q, shift_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       rem_q, rem_d;
  logic [2:0]       addr_q, addr_d;
  logic [2:0]       prev_q, prev_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [SMP_W-1:0] smp_data_q, smp_data_d;
  logic [2:0]       smp_chan_q, smp_chan_d;
  logic             smp_valid_q, smp_valid_d;
  logic             overrun_q, overrun_d;

  logic             tmr_tc;
  logic             scan_req;
  logic             start_acc;
  logic             sample_dout;
  logic             new_smp;
  logic [2:0]       first_ch;
  logic [2:0]       rem_ch;
  logic [15:0]      frame_word;

  function automatic logic [2:0] lowest_chan(input logic [7:0] m);
    lowest_chan = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_chan = 3'(i);
    end
  endfunction

  function automatic logic [7:0] chan_bit(input logic [2:0] c);
    chan_bit = 8'd1 << c;
  endfunction

  assign tmr_tc      = (tmr_q == 8'd0);
  assign scan_req    = start && (chan_mask != 8'd0);
  assign start_acc   = (state_q == S_IDLE) && scan_req;
  // first cycle of the sclk high phase
  assign sample_dout = (state_q == S_SHIFT) && phase_q && (tmr_q == TMR_LOAD);
  // first HOLD cycle of a frame whose result is wanted
  assign new_smp     = (state_q == S_HOLD) && (tmr_q == TMR_LOAD) && !first_q;
  assign first_ch    = lowest_chan(chan_mask);
  assign rem_ch      = lowest_chan(rem_q);
  assign frame_word  = {2'b00, addr_q, 11'd0};

  assign adc_0_cs_n = !((state_q == S_SETUP) || (state_q == S_SHIFT));
  assign adc_0_sclk = (state_q == S_SHIFT) ? phase_q : 1'b1;
  assign adc_0_din  = (state_q == S_SHIFT) ? frame_word[4'd15 - bit_q] : 1'b0;
  assign busy       = (state_q != S_IDLE);
  assign smp_data   = smp_data_q;
  assign smp_chan   = smp_chan_q;
  assign smp_valid  = smp_valid_q;
  assign overrun    = overrun_q;

  // Frame sequencing, sclk timing and channel walk.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shift_d = shift_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    prev_d  = prev_q;
    first_d = first_q;
    last_d  = last_q;

    if (!tmr_tc) tmr_d = tmr_q - 8'd1;
    if (sample_dout) shift_d = {shift_q[SMP_W-2:0], adc_0_dout};

    case (state_q)
      S_IDLE: begin
        if (scan_req) begin
          state_d = S_SETUP;
          tmr_d   = TMR_LOAD;
          mask_d  = chan_mask;
          addr_d  = first_ch;
          rem_d   = chan_mask & ~chan_bit(first_ch);
          first_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (tmr_tc) begin
          state_d = S_SHIFT;
          tmr_d   = TMR_LOAD;
          bit_d   = 4'd0;
          phase_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (tmr_tc) begin
          tmr_d = TMR_LOAD;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == 4'd15) begin
            state_d = S_HOLD;
            phase_d = 1'b0;
            bit_d   = 4'd0;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (tmr_tc) begin
          if (!last_q) begin
            // more frames in this scan; once every enabled address has been
            // sent, the closing frame re-sends the first one
            state_d = S_SETUP;
            tmr_d   = TMR_LOAD;
            prev_d  = addr_q;
            first_d = 1'b0;
            if (rem_q != 8'd0) begin
              addr_d = rem_ch;
              rem_d  = rem_q & ~chan_bit(rem_ch);
            end else begin
              addr_d = lowest_chan(mask_q);
              last_d = 1'b1;
            end
          end else if (continuous && (chan_mask != 8'd0)) begin
            state_d = S_SETUP;
            tmr_d   = TMR_LOAD;
            mask_d  = chan_mask;
            addr_d  = first_ch;
            rem_d   = chan_mask & ~chan_bit(first_ch);
            first_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sample hand-off: hold until accepted, drop and flag on collision.
  always_comb begin
    smp_data_d  = smp_data_q;
    smp_chan_d  = smp_chan_q;
    smp_valid_d = smp_valid_q;
    overrun_d   = overrun_q;

    if (start_acc) overrun_d = 1'b0;

    if (new_smp) begin
      if (smp_valid_q && !smp_ready) begin
        overrun_d = 1'b1;
      end else begin
        smp_data_d  = shift_q;
        smp_chan_d  = prev_q;
        smp_valid_d = 1'b1;
      end
    end else if (smp_valid_q && smp_ready) begin
      smp_valid_d = 1'b0;
    end
  end

  // State registers; reset drops cs_n at once and discards any frame.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= 8'd0;
      bit_q       <= 4'd0;
      phase_q     <= 1'b0;
      shift_q     <= '0;
      mask_q      <= 8'd0;
      rem_q       <= 8'd0;
      addr_q      <= 3'd0;
      prev_q      <= 3'd0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      smp_data_q  <= '0;
      smp_chan_q  <= 3'd0;
      smp_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      mask_q      <= mask_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      last_q      <= last_d;
      smp_data_q  <= smp_data_d;
      smp_chan_q  <= smp_chan_d;
      smp_valid_q <= smp_valid_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl with CLK_DIV=2 (68-cycle frames) and an ADC model.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [7:0]  chan_mask = 8'h00;
  logic        adc_0_sclk;
  logic        adc_0_cs_n;
  logic        adc_0_din;
  logic        adc_0_dout = 1'b0;
  logic [11:0] smp_data;
  logic [2:0]  smp_chan;
  logic        smp_valid;
  logic        smp_ready = 1'b0;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  adc_scan_ctrl #(.CLK_DIV(2), .SMP_W(12)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
    .continuous(continuous), .chan_mask(chan_mask),
    .adc_0_sclk(adc_0_sclk), .adc_0_cs_n(adc_0_cs_n), .adc_0_din(adc_0_din),
    .adc_0_dout(adc_0_dout), .smp_data(smp_data), .smp_chan(smp_chan),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk_clk = ~clk_clk;

  // ADC model: mode 0 returns model_const, mode 1 returns 0x100 + channel
  int          model_mode = 0;
  logic [11:0] model_const = 12'h000;
  logic [15:0] cur_word = 16'h0;
  int          bit_k = 0;
  logic [15:0] din_sh = 16'h0;
  logic [2:0]  prev_addr = 3'd0;
  logic [2:0]  f_addr[$];
  logic [2:0]  q_chan[$];
  logic [11:0] q_data[$];

  always @(negedge adc_0_cs_n) begin
    cur_word = (model_mode == 0) ? {4'h0, model_const} : {4'h0, 12'h100 | {9'd0, prev_addr}};
    bit_k = 0;
    din_sh = 16'h0;
  end

  always @(negedge adc_0_sclk) begin
    if (adc_0_cs_n == 1'b0 && bit_k < 16) begin
      adc_0_dout = cur_word[15 - bit_k];
      bit_k++;
    end
  end

  always @(posedge adc_0_sclk) begin
    if (adc_0_cs_n == 1'b0) din_sh = {din_sh[14:0], adc_0_din};
  end

  always @(posedge adc_0_cs_n) begin
    prev_addr = din_sh[13:11];
    f_addr.push_back(din_sh[13:11]);
  end

  always @(negedge clk_clk) begin
    if (smp_valid === 1'b1 && smp_ready === 1'b1) begin
      q_chan.push_back(smp_chan);
      q_data.push_back(smp_data);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [2:0] exp_ch[4]   = '{3'd0, 3'd2, 3'd5, 3'd7};
  logic [2:0] exp_addr[5] = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0};

  task automatic pulse_start();
    @(posedge clk_clk); #1;
    start = 1'b1;
    @(posedge clk_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, output bit to);
    int n;
    n = 0; cyc = 0; to = 1'b1;
    while (n < 5000) begin
      @(negedge clk_clk);
      n++;
      if (!busy) begin
        to = 1'b0;
        break;
      end
      cyc++;
    end
  endtask

  task automatic clear_logs();
    f_addr.delete();
    q_chan.delete();
    q_data.delete();
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    checks++; if (adc_0_cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", adc_0_cs_n); end
    checks++; if (adc_0_sclk !== 1'b1) begin failures++; $display("FAIL rst_sclk got=%b exp=1", adc_0_sclk); end
    checks++; if (adc_0_din !== 1'b0) begin failures++; $display("FAIL rst_din got=%b exp=0", adc_0_din); end
    checks++; if (smp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", smp_valid); end
    checks++; if (smp_data !== 12'h000) begin failures++; $display("FAIL rst_data got=%h exp=000", smp_data); end
    checks++; if (smp_chan !== 3'd0) begin failures++; $display("FAIL rst_chan got=%0d exp=0", smp_chan); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
  endtask

  task automatic test_single();
    int cyc; bit to;
    model_mode = 0; model_const = 12'hABC;
    smp_ready = 1'b1; continuous = 1'b0; chan_mask = 8'h01;
    clear_logs();
    pulse_start();
    wait_idle(cyc, to);
    repeat (4) @(negedge clk_clk);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", to); end
    checks++; if (cyc != 136) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=136", cyc); end
    checks++; if (f_addr.size() != 2) begin failures++; $display("FAIL single_frames got=%0d exp=2", f_addr.size()); end
    for (int i = 0; i < f_addr.size(); i++) begin
      checks++; if (f_addr[i] !== 3'd0) begin failures++; $display("FAIL single_addr[%0d] got=%0d exp=0", i, f_addr[i]); end
    end
    checks++;
    if (q_chan.size() != 1) begin
      failures++; $display("FAIL single_nsamples got=%0d exp=1", q_chan.size());
    end else begin
      checks++; if (q_chan[0] !== 3'd0) begin failures++; $display("FAIL single_chan got=%0d exp=0", q_chan[0]); end
      checks++; if (q_data[0] !== 12'hABC) begin failures++; $display("FAIL single_data got=%h exp=abc", q_data[0]); end
    end
  endtask

  task automatic test_multi();
    int cyc; bit to;
    model_mode = 1; smp_ready = 1'b1; chan_mask = 8'hA5;
    clear_logs();
    pulse_start();
    wait_idle(cyc, to);
    repeat (4) @(negedge clk_clk);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL multi_timeout got=%b exp=0", to); end
    checks++; if (cyc != 340) begin failures++; $display("FAIL multi_busy_cycles got=%0d exp=340", cyc); end
    checks++; if (f_addr.size() != 5) begin failures++; $display("FAIL multi_frames got=%0d exp=5", f_addr.size()); end
    for (int i = 0; i < 5 && i < f_addr.size(); i++) begin
      checks++; if (f_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL multi_addr[%0d] got=%0d exp=%0d", i, f_addr[i], exp_addr[i]); end
    end
    checks++; if (q_chan.size() != 4) begin failures++; $display("FAIL multi_nsamples got=%0d exp=4", q_chan.size()); end
    for (int i = 0; i < 4 && i < q_chan.size(); i++) begin
      checks++; if (q_chan[i] !== exp_ch[i]) begin failures++; $display("FAIL multi_chan[%0d] got=%0d exp=%0d", i, q_chan[i], exp_ch[i]); end
      checks++; if (q_data[i] !== (12'h100 | {9'd0, exp_ch[i]})) begin failures++; $display("FAIL multi_data[%0d] got=%h exp=%h", i, q_data[i], 12'h100 | {9'd0, exp_ch[i]}); end
    end
  endtask

  task automatic test_overrun();
    int n; bit to; bit unstable; int cyc;
    model_mode = 1; smp_ready = 1'b0; chan_mask = 8'h03;
    clear_logs();
    pulse_start();
    n = 0; to = 1'b1; unstable = 1'b0;
    while (n < 5000) begin
      @(negedge clk_clk);
      n++;
      if (smp_valid === 1'b1 && (smp_data !== 12'h100 || smp_chan !== 3'd0)) unstable = 1'b1;
      if (!busy) begin to = 1'b0; break; end
    end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL ovr_timeout got=%b exp=0", to); end
    checks++; if (unstable !== 1'b0) begin failures++; $display("FAIL ovr_held_stable got=%b exp=0", unstable); end
    checks++; if (smp_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", smp_valid); end
    checks++; if (smp_chan !== 3'd0) begin failures++; $display("FAIL ovr_chan got=%0d exp=0", smp_chan); end
    checks++; if (smp_data !== 12'h100) begin failures++; $display("FAIL ovr_data got=%h exp=100", smp_data); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    @(posedge clk_clk); #1;
    smp_ready = 1'b1;
    @(posedge clk_clk); #1;
    smp_ready = 1'b0;
    checks++; if (smp_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept_clear got=%b exp=0", smp_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    model_mode = 0; model_const = 12'h321; chan_mask = 8'h01; smp_ready = 1'b1;
    pulse_start();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_start_clears got=%b exp=0", overrun); end
    wait_idle(cyc, to);
    repeat (4) @(negedge clk_clk);
  endtask

  task automatic test_continuous();
    int n, cyc; bit to, to2, gap, bad;
    model_mode = 1; smp_ready = 1'b1; chan_mask = 8'h80; continuous = 1'b1;
    clear_logs();
    pulse_start();
    n = 0; to = 1'b1; gap = 1'b0;
    while (n < 2000) begin
      @(negedge clk_clk);
      n++;
      if (busy !== 1'b1) gap = 1'b1;
      if (q_chan.size() >= 3) begin to = 1'b0; break; end
    end
    @(posedge clk_clk); #1;
    continuous = 1'b0;
    wait_idle(cyc, to2);
    repeat (4) @(negedge clk_clk);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL cont_timeout got=%b exp=0", to); end
    checks++; if (gap !== 1'b0) begin failures++; $display("FAIL cont_no_gap got=%b exp=0", gap); end
    checks++; if (to2 !== 1'b0) begin failures++; $display("FAIL cont_stop_timeout got=%b exp=0", to2); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_busy got=%b exp=0", busy); end
    checks++; if ((f_addr.size() % 2) != 0) begin failures++; $display("FAIL cont_whole_scans got=%0d exp=even", f_addr.size()); end
    checks++; if (q_chan.size() != f_addr.size() / 2) begin failures++; $display("FAIL cont_nsamples got=%0d exp=%0d", q_chan.size(), f_addr.size() / 2); end
    bad = 1'b0;
    for (int i = 0; i < q_chan.size(); i++) if (q_chan[i] !== 3'd7 || q_data[i] !== 12'h107) bad = 1'b1;
    for (int i = 0; i < f_addr.size(); i++) if (f_addr[i] !== 3'd7) bad = 1'b1;
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL cont_content got=%b exp=0", bad); end
  endtask

  task automatic test_ignored();
    int n, cyc; bit act, to;
    chan_mask = 8'h00; smp_ready = 1'b1; model_mode = 0; model_const = 12'h0F0;
    clear_logs();
    pulse_start();
    act = 1'b0;
    repeat (10) begin
      @(negedge clk_clk);
      if (adc_0_cs_n !== 1'b1 || busy !== 1'b0) act = 1'b1;
    end
    checks++; if (act !== 1'b0) begin failures++; $display("FAIL ign_zero_mask got=%b exp=0", act); end
    chan_mask = 8'h01;
    pulse_start();
    n = 0; cyc = 0; to = 1'b1;
    while (n < 5000) begin
      @(negedge clk_clk);
      n++;
      if (n == 20) begin chan_mask = 8'hFF; start = 1'b1; end
      if (n == 21) start = 1'b0;
      if (!busy) begin to = 1'b0; break; end
      cyc++;
    end
    repeat (4) @(negedge clk_clk);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL ign_timeout got=%b exp=0", to); end
    checks++; if (cyc != 136) begin failures++; $display("FAIL ign_busy_cycles got=%0d exp=136", cyc); end
    checks++; if (f_addr.size() != 2) begin failures++; $display("FAIL ign_frames got=%0d exp=2", f_addr.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    model_mode = 0; model_const = 12'h5A5; smp_ready = 1'b1; chan_mask = 8'h01;
    clear_logs();
    pulse_start();
    @(negedge clk_clk);
    repeat (30) @(negedge clk_clk);
    checks++; if (adc_0_cs_n !== 1'b0 || adc_0_sclk !== 1'b0) begin failures++; $display("FAIL rmid_pre got=cs%b/sclk%b exp=cs0/sclk0", adc_0_cs_n, adc_0_sclk); end
    #1;
    reset_reset_n = 1'b0;
    #1;
    checks++; if (adc_0_cs_n !== 1'b1) begin failures++; $display("FAIL rmid_cs_n got=%b exp=1", adc_0_cs_n); end
    checks++; if (adc_0_sclk !== 1'b1) begin failures++; $display("FAIL rmid_sclk got=%b exp=1", adc_0_sclk); end
    checks++; if (smp_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", smp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    clear_logs();
    pulse_start();
    wait_idle(cyc, to);
    repeat (4) @(negedge clk_clk);
    checks++; if (to !== 1'b0 || cyc != 136) begin failures++; $display("FAIL rmid_fresh_cycles got=%0d exp=136", cyc); end
    checks++;
    if (q_chan.size() != 1) begin
      failures++; $display("FAIL rmid_nsamples got=%0d exp=1", q_chan.size());
    end else begin
      checks++; if (q_chan[0] !== 3'd0 || q_data[0] !== 12'h5A5) begin failures++; $display("FAIL rmid_sample got=%0d/%h exp=0/5a5", q_chan[0], q_data[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_overrun();
    test_continuous();
    test_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
